// File: rtl/wired_bus_resolver.sv
// rtl/wired_bus_resolver.sv - registered multi-driver shared-bus resolver
//
// Purpose:
//   Resolves N_DRV enabled drivers into one registered bus value using a
//   wired-OR (MODE 0), wired-AND (MODE 1) or tri-state (MODE 2) rule.
//   It also flags contention, keeps a saturating count of conflict cycles,
//   and holds the last value while no driver is enabled (keeper). A watchdog
//   FSM declares the bus floating after FLOAT_LIMIT idle cycles.
//
// Optional feature (macro WIRED_BUS_CONFLICT_LOG_EN):
//   Adds conflict_mask / log_valid. They capture drv_en on the first
//   conflict after rst or cnt_clr and stay sticky until rst or cnt_clr.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   drv_en        in   [N_DRV]        per-driver enable
//   drv_data      in   [N_DRV*WIDTH]  driver i at [i*WIDTH +: WIDTH]
//   cnt_clr       in   synchronous clear of conflict_cnt (and the log)
//   bus_out       out  [WIDTH]        registered resolved bus
//   bus_valid     out  bus_out came from at least one enabled driver
//   conflict      out  one-cycle registered contention pulse
//   conflict_cnt  out  [CNT_W]        saturating conflict-cycle count
//   float_flag    out  high while the watchdog FSM is in FLOAT
//   conflict_mask out  [N_DRV] (optional) drv_en at the first logged conflict
//   log_valid     out  (optional) conflict_mask holds a capture

module wired_bus_resolver #(
  parameter int N_DRV       = 4,
  parameter int WIDTH       = 8,
  parameter int MODE        = 0,
  parameter int FLOAT_LIMIT = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_DRV-1:0]       drv_en,
  input  logic [N_DRV*WIDTH-1:0] drv_data,
  input  logic                   cnt_clr,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid,
  output logic                   conflict,
  output logic [CNT_W-1:0]       conflict_cnt,
  output logic                   float_flag
`ifdef WIRED_BUS_CONFLICT_LOG_EN
  ,
  output logic [N_DRV-1:0]       conflict_mask,
  output logic                   log_valid
`endif
);

  // Value the bus takes after reset and when declared floating.
  localparam logic [WIDTH-1:0] IDLE_VAL = (MODE == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  // Idle counter only needs to reach FLOAT_LIMIT.
  localparam int                IDLE_W   = (FLOAT_LIMIT < 2) ? 1 : $clog2(FLOAT_LIMIT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(FLOAT_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    HOLD   = 2'd1,
    FLOAT  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_nxt;
  logic [IDLE_W-1:0] idle_inc;
  logic [WIDTH-1:0]  bus_nxt;
  logic              valid_nxt;

  logic [WIDTH-1:0]  or_val;
  logic [WIDTH-1:0]  and_val;
  logic [WIDTH-1:0]  resolved;
  logic              any_en;
  logic              multi_en;
  logic              conflict_nxt;

  // Fold only enabled lanes. Gating on the enable (rather than masking the
  // data) keeps unknown data on disabled drivers from reaching the result.
  always_comb begin
    or_val  = '0;
    and_val = '1;
    for (int i = 0; i < N_DRV; i++) begin
      if (drv_en[i]) begin
        or_val  = or_val  | drv_data[i*WIDTH +: WIDTH];
        and_val = and_val & drv_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign resolved = (MODE == 1) ? and_val : or_val;
  assign any_en   = |drv_en;

  // Clearing the lowest set bit leaves something only when two or more
  // enables are high.
  assign multi_en = |(drv_en & (drv_en - N_DRV'(1)));

  // Enabled drivers disagree on some bit exactly when their OR and AND differ.
  // Tri-state contention is any overlap, regardless of data.
  assign conflict_nxt = multi_en && ((MODE == 2) || (or_val != and_val));

  assign idle_inc = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IDLE_W'(1);

  // Watchdog / keeper next-state logic.
  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    bus_nxt   = bus_out;
    valid_nxt = 1'b0;
    if (any_en) begin
      state_nxt = ACTIVE;
      idle_nxt  = '0;
      bus_nxt   = resolved;
      valid_nxt = 1'b1;
    end else begin
      case (state)
        FLOAT: begin
          state_nxt = FLOAT;
        end
        default: begin
          // ACTIVE or HOLD with no driver: keep the bus until the limit.
          idle_nxt = idle_inc;
          if (idle_inc == IDLE_MAX) begin
            state_nxt = FLOAT;
            bus_nxt   = IDLE_VAL;
          end else begin
            state_nxt = HOLD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      idle_cnt  <= '0;
      bus_out   <= IDLE_VAL;
      bus_valid <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      state     <= state_nxt;
      idle_cnt  <= idle_nxt;
      bus_out   <= bus_nxt;
      bus_valid <= valid_nxt;
      conflict  <= conflict_nxt;
    end
  end

  // Clear wins over a same-cycle increment; the pulse itself is unaffected.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      conflict_cnt <= '0;
    end else if (conflict_nxt && (conflict_cnt != CNT_MAX)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  assign float_flag = (state == FLOAT);

`ifdef WIRED_BUS_CONFLICT_LOG_EN
  // First conflict after rst/cnt_clr is captured; later ones are ignored.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      conflict_mask <= '0;
      log_valid     <= 1'b0;
    end else if (conflict_nxt && !log_valid) begin
      conflict_mask <= drv_en;
      log_valid     <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wired_bus_resolver.sv
// tb/tb_wired_bus_resolver.sv - scoreboard bench for wired_bus_resolver
//
// Three instances share one stimulus stream:
//   inst0: MODE 0, FLOAT_LIMIT 4, CNT_W 8
//   inst1: MODE 1, FLOAT_LIMIT 1, CNT_W 8
//   inst2: MODE 2, FLOAT_LIMIT 4, CNT_W 2

module tb_wired_bus_resolver;

  logic        clk;
  logic        rst;
  logic [3:0]  drv_en;
  logic [31:0] drv_data;
  logic        cnt_clr;

  logic [7:0]  bus_a, bus_b, bus_c;
  logic        val_a, val_b, val_c;
  logic        con_a, con_b, con_c;
  logic [7:0]  cnt_a, cnt_b;
  logic [1:0]  cnt_c;
  logic        flt_a, flt_b, flt_c;
`ifdef WIRED_BUS_CONFLICT_LOG_EN
  logic [3:0]  msk_a, msk_b, msk_c;
  logic        lgv_a, lgv_b, lgv_c;
`endif

  wired_bus_resolver #(.N_DRV(4), .WIDTH(8), .MODE(0), .FLOAT_LIMIT(4), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .drv_en(drv_en), .drv_data(drv_data), .cnt_clr(cnt_clr),
    .bus_out(bus_a), .bus_valid(val_a), .conflict(con_a), .conflict_cnt(cnt_a),
    .float_flag(flt_a)
`ifdef WIRED_BUS_CONFLICT_LOG_EN
    , .conflict_mask(msk_a), .log_valid(lgv_a)
`endif
  );

  wired_bus_resolver #(.N_DRV(4), .WIDTH(8), .MODE(1), .FLOAT_LIMIT(1), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .drv_en(drv_en), .drv_data(drv_data), .cnt_clr(cnt_clr),
    .bus_out(bus_b), .bus_valid(val_b), .conflict(con_b), .conflict_cnt(cnt_b),
    .float_flag(flt_b)
`ifdef WIRED_BUS_CONFLICT_LOG_EN
    , .conflict_mask(msk_b), .log_valid(lgv_b)
`endif
  );

  wired_bus_resolver #(.N_DRV(4), .WIDTH(8), .MODE(2), .FLOAT_LIMIT(4), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .drv_en(drv_en), .drv_data(drv_data), .cnt_clr(cnt_clr),
    .bus_out(bus_c), .bus_valid(val_c), .conflict(con_c), .conflict_cnt(cnt_c),
    .float_flag(flt_c)
`ifdef WIRED_BUS_CONFLICT_LOG_EN
    , .conflict_mask(msk_c), .log_valid(lgv_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0][7:0] bus;
    logic [2:0]      valid;
    logic [2:0]      conf;
    logic [2:0][7:0] cnt;
    logic [2:0]      flt;
    logic [2:0][3:0] mask;
    logic [2:0]      logv;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one slot per instance.
  logic [7:0] m_bus   [3];
  logic       m_valid [3];
  logic       m_conf  [3];
  int         m_cnt   [3];
  int         m_idle  [3];
  logic       m_flt   [3];
  logic [3:0] m_mask  [3];
  logic       m_log   [3];

  function automatic int mode_of(int k);
    return k;
  endfunction

  function automatic int limit_of(int k);
    return (k == 1) ? 1 : 4;
  endfunction

  function automatic int cmax_of(int k);
    return (k == 2) ? 3 : 255;
  endfunction

  // Applies the rules to the list of enabled driver values.
  task automatic model_step(input logic r, input logic [3:0] en, input logic [31:0] d,
                            input logic clr, output exp_t e);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] vals[$];
      logic [7:0] res;
      logic [7:0] idle_v;
      bit         differ;
      bit         conf;
      idle_v = (mode_of(k) == 1) ? 8'hFF : 8'h00;
      vals = {};
      for (int i = 0; i < 4; i++) if (en[i]) vals.push_back(d[i*8 +: 8]);
      res = (mode_of(k) == 1) ? 8'hFF : 8'h00;
      differ = 0;
      foreach (vals[j]) begin
        if (mode_of(k) == 1) res = res & vals[j];
        else                 res = res | vals[j];
        if (vals[j] != vals[0]) differ = 1;
      end
      conf = (vals.size() >= 2) && ((mode_of(k) == 2) || differ);
      if (r) begin
        m_bus[k] = idle_v; m_valid[k] = 0; m_conf[k] = 0; m_cnt[k] = 0;
        m_idle[k] = 0; m_flt[k] = 0; m_mask[k] = 0; m_log[k] = 0;
      end else begin
        if (vals.size() > 0) begin
          m_bus[k] = res; m_valid[k] = 1; m_idle[k] = 0; m_flt[k] = 0;
        end else begin
          m_valid[k] = 0;
          if (!m_flt[k]) begin
            if (m_idle[k] < limit_of(k)) m_idle[k]++;
            if (m_idle[k] == limit_of(k)) begin
              m_flt[k] = 1;
              m_bus[k] = idle_v;
            end
          end
        end
        m_conf[k] = conf;
        if (clr) m_cnt[k] = 0;
        else if (conf && m_cnt[k] < cmax_of(k)) m_cnt[k]++;
        if (clr) begin
          m_mask[k] = 0; m_log[k] = 0;
        end else if (conf && !m_log[k]) begin
          m_mask[k] = en; m_log[k] = 1;
        end
      end
      e.bus[k]   = m_bus[k];
      e.valid[k] = m_valid[k];
      e.conf[k]  = m_conf[k];
      e.cnt[k]   = 8'(m_cnt[k]);
      e.flt[k]   = m_flt[k];
      e.mask[k]  = m_mask[k];
      e.logv[k]  = m_log[k];
    end
  endtask

  // Inputs change on the falling edge; expected result queued at the same time.
  task automatic drive(input logic r, input logic [3:0] en, input logic [31:0] d, input logic clr);
    exp_t e;
    logic [31:0] dd;
    @(negedge clk);
    dd = d;
    for (int i = 0; i < 4; i++) if (!en[i]) dd[i*8 +: 8] = 8'hxx;
    rst = r; drv_en = en; drv_data = dd; cnt_clr = clr;
    model_step(r, en, d, clr, e);
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Monitor: every cycle each instance presents a registered result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("bus_out", 0, bus_a, e.bus[0]);
        check("bus_out", 1, bus_b, e.bus[1]);
        check("bus_out", 2, bus_c, e.bus[2]);
        check("bus_valid", 0, {7'd0, val_a}, {7'd0, e.valid[0]});
        check("bus_valid", 1, {7'd0, val_b}, {7'd0, e.valid[1]});
        check("bus_valid", 2, {7'd0, val_c}, {7'd0, e.valid[2]});
        check("conflict", 0, {7'd0, con_a}, {7'd0, e.conf[0]});
        check("conflict", 1, {7'd0, con_b}, {7'd0, e.conf[1]});
        check("conflict", 2, {7'd0, con_c}, {7'd0, e.conf[2]});
        check("conflict_cnt", 0, cnt_a, e.cnt[0]);
        check("conflict_cnt", 1, cnt_b, e.cnt[1]);
        check("conflict_cnt", 2, {6'd0, cnt_c}, e.cnt[2]);
        check("float_flag", 0, {7'd0, flt_a}, {7'd0, e.flt[0]});
        check("float_flag", 1, {7'd0, flt_b}, {7'd0, e.flt[1]});
        check("float_flag", 2, {7'd0, flt_c}, {7'd0, e.flt[2]});
`ifdef WIRED_BUS_CONFLICT_LOG_EN
        check("conflict_mask", 0, {4'd0, msk_a}, {4'd0, e.mask[0]});
        check("conflict_mask", 1, {4'd0, msk_b}, {4'd0, e.mask[1]});
        check("conflict_mask", 2, {4'd0, msk_c}, {4'd0, e.mask[2]});
        check("log_valid", 0, {7'd0, lgv_a}, {7'd0, e.logv[0]});
        check("log_valid", 1, {7'd0, lgv_b}, {7'd0, e.logv[1]});
        check("log_valid", 2, {7'd0, lgv_c}, {7'd0, e.logv[2]});
`endif
      end
    end
  end

  initial begin
    logic [3:0]  en;
    logic [31:0] d;
    rst = 1'b1; drv_en = '0; drv_data = '0; cnt_clr = 1'b0;

    // Reset, then two idle cycles.
    drive(1, 4'b0000, 32'h0, 0);
    drive(0, 4'b0000, 32'h0, 0);
    drive(0, 4'b0000, 32'h0, 0);
    // Differing drivers, then agreeing drivers.
    drive(0, 4'b0011, 32'h0000_F00F, 0);
    drive(0, 4'b0011, 32'h0000_3C3C, 0);
    // AND-style pattern.
    drive(0, 4'b1010, 32'h3F00_F300, 0);
    // Single driver, idle into FLOAT, then exit.
    drive(0, 4'b0100, 32'h00A5_0000, 0);
    for (int i = 0; i < 4; i++) drive(0, 4'b0000, 32'h0, 0);
    drive(0, 4'b0001, 32'h0000_005A, 0);
    // Counter saturation, then clear together with a conflict.
    for (int i = 0; i < 5; i++) drive(0, 4'b0011, $urandom, 0);
    drive(0, 4'b1100, 32'h1234_5678, 1);
    // Reset in ACTIVE.
    drive(0, 4'b0001, 32'h0000_0077, 0);
    drive(1, 4'b0010, 32'h0000_1100, 0);
    // Two logged conflicts; the first must stick.
    drive(0, 4'b0110, 32'h0011_2200, 0);
    drive(0, 4'b1001, 32'h4400_0088, 0);
    drive(0, 4'b0000, 32'h0, 0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      d  = $urandom;
      if ($urandom_range(0, 3) == 0) d = {4{d[7:0]}};
      drive(($urandom_range(0, 59) == 0), en, d, ($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
